ext_alu_ctrl: RTL and testbench

Sequencer for the multi-cycle extended ALU (MUL, UMUL, ADDF, SUBF, MULF, ITF, FTI).
- Accepts one operation per start pulse from the EX stage.
- Registers the operands and func and holds them stable on the extended ALU inputs for the op's latency.
- Stalls the front of the pipeline while the op runs, then captures the result and flags into dst_EX_DM, ov, zr and neg with a one-cycle done pulse.

---
 rtl/ext_alu_pkg.sv | 61 ++++++
 rtl/ext_alu_lat_lut.sv | 27 ++
 rtl/ext_alu_ctrl.sv | 157 +++++++++++++++
 tb/tb_ext_alu_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_alu_pkg.sv
// Shared definitions for the extended-ALU sequencer: function codes, FSM states,
// default latencies and the counter sizing helpers.
package ext_alu_pkg;

    typedef enum logic [2:0] {
        FUNC_MUL   = 3'b000,
        FUNC_UMUL  = 3'b001,
        FUNC_ADDF  = 3'b010,
        FUNC_SUBF  = 3'b011,
        FUNC_MULF  = 3'b100,
        FUNC_ITF   = 3'b101,
        FUNC_FTI   = 3'b110,
        FUNC_UNDEF = 3'b111
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_LAT_MUL  = 2;
    localparam int DEF_LAT_FADD = 3;
    localparam int DEF_LAT_FMUL = 4;
    localparam int DEF_LAT_CVT  = 2;

    function automatic int max_lat(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        if (d > m) begin
            m = d;
        end else begin
            m = m;
        end
        return m;
    endfunction

    // A single-cycle maximum still needs a one-bit counter to keep ports legal.
    function automatic int cnt_width(input int lat_max);
        int w;
        w = $clog2(lat_max);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/ext_alu_lat_lut.sv
// Combinational lookup from function code to (latency - 1), the counter preload.
module ext_alu_lat_lut
    import ext_alu_pkg::*;
#(
    parameter int LAT_MUL  = DEF_LAT_MUL,
    parameter int LAT_FADD = DEF_LAT_FADD,
    parameter int LAT_FMUL = DEF_LAT_FMUL,
    parameter int LAT_CVT  = DEF_LAT_CVT,
    parameter int CNT_W    = 2
) (
    input  logic [2:0]       func,
    output logic [CNT_W-1:0] lat_m1
);

    // Undefined codes preload zero; they never enter the counting state.
    always_comb begin
        lat_m1 = '0;
        case (func_e'(func))
            FUNC_MUL, FUNC_UMUL:  lat_m1 = CNT_W'(LAT_MUL - 1);
            FUNC_ADDF, FUNC_SUBF: lat_m1 = CNT_W'(LAT_FADD - 1);
            FUNC_MULF:            lat_m1 = CNT_W'(LAT_FMUL - 1);
            FUNC_ITF, FUNC_FTI:   lat_m1 = CNT_W'(LAT_CVT - 1);
            default:              lat_m1 = '0;
        endcase
    end

endmodule

// File: rtl/ext_alu_ctrl.sv
// Sequencer for the multi-cycle extended ALU: latches an op, holds its operands
// for the op latency while stalling the front end, then captures result and flags.
module ext_alu_ctrl
    import ext_alu_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LAT_MUL  = DEF_LAT_MUL,
    parameter int LAT_FADD = DEF_LAT_FADD,
    parameter int LAT_FMUL = DEF_LAT_FMUL,
    parameter int LAT_CVT  = DEF_LAT_CVT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src0,
    input  logic             flush,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_ov,
    input  logic             alu_zr,
    input  logic             alu_neg,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src0,
    output logic [2:0]       alu_func,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dst_EX_DM,
    output logic             ov,
    output logic             zr,
    output logic             neg,
    output logic             illegal
);

    localparam int LAT_MAX = max_lat(LAT_MUL, LAT_FADD, LAT_FMUL, LAT_CVT);
    localparam int CNT_W   = cnt_width(LAT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic [WIDTH-1:0] src0_q, src0_d;
    logic [2:0]       func_q, func_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic             ov_q, ov_d;
    logic             zr_q, zr_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] lat_m1_s;

    ext_alu_lat_lut #(
        .LAT_MUL  (LAT_MUL),
        .LAT_FADD (LAT_FADD),
        .LAT_FMUL (LAT_FMUL),
        .LAT_CVT  (LAT_CVT),
        .CNT_W    (CNT_W)
    ) u_lat_lut (
        .func   (func),
        .lat_m1 (lat_m1_s)
    );

    // Next-state logic: flush beats completion, completion beats a new issue.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src1_d    = src1_q;
        src0_d    = src0_q;
        func_d    = func_q;
        dst_d     = dst_q;
        ov_d      = ov_q;
        zr_d      = zr_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_EXEC) begin
            if (cnt_q == '0) begin
                state_d = ST_DONE;
                dst_d   = alu_res;
                ov_d    = alu_ov;
                zr_d    = alu_zr;
                neg_d   = alu_neg;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (start) begin
            src1_d = src1;
            src0_d = src0;
            func_d = func;
            cnt_d  = lat_m1_s;
            if (func == FUNC_UNDEF) begin
                state_d   = ST_DONE;
                dst_d     = '0;
                ov_d      = 1'b0;
                zr_d      = 1'b0;
                neg_d     = 1'b0;
                done_d    = 1'b1;
                illegal_d = 1'b1;
            end else begin
                state_d = ST_EXEC;
            end
        end else begin
            state_d = ST_IDLE;
        end
        busy_d = (state_d == ST_EXEC);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            src1_q    <= '0;
            src0_q    <= '0;
            func_q    <= 3'b000;
            dst_q     <= '0;
            ov_q      <= 1'b0;
            zr_q      <= 1'b0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src1_q    <= src1_d;
            src0_q    <= src0_d;
            func_q    <= func_d;
            dst_q     <= dst_d;
            ov_q      <= ov_d;
            zr_q      <= zr_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
        end
    end

    // Stall must react in the issue cycle itself, so it is not registered.
    assign stall     = (start && (state_q != ST_EXEC)) || (state_q == ST_EXEC);
    assign busy      = busy_q;
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign alu_src1  = src1_q;
    assign alu_src0  = src0_q;
    assign alu_func  = func_q;
    assign dst_EX_DM = dst_q;
    assign ov        = ov_q;
    assign zr        = zr_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_ext_alu_ctrl.sv
// Randomised and directed bench for ext_alu_ctrl against a cycle-timeline model.
module tb_ext_alu_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   func = 3'b000;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src0 = '0;
    logic [W-1:0] alu_res = '0;
    logic         alu_ov = 1'b0;
    logic         alu_zr = 1'b0;
    logic         alu_neg = 1'b0;
    logic [W-1:0] alu_src1, alu_src0, dst_EX_DM;
    logic [2:0]   alu_func;
    logic         stall, busy, done, ov, zr, neg, illegal;

    ext_alu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .func      (func),
        .src1      (src1),
        .src0      (src0),
        .flush     (flush),
        .alu_res   (alu_res),
        .alu_ov    (alu_ov),
        .alu_zr    (alu_zr),
        .alu_neg   (alu_neg),
        .alu_src1  (alu_src1),
        .alu_src0  (alu_src0),
        .alu_func  (alu_func),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .dst_EX_DM (dst_EX_DM),
        .ov        (ov),
        .zr        (zr),
        .neg       (neg),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [2:0] f);
        case (f)
            3'd0, 3'd1: return 2;
            3'd2, 3'd3: return 3;
            3'd4:       return 4;
            3'd5, 3'd6: return 2;
            default:    return 0;
        endcase
    endfunction

    // Stand-in ALU behaviour: {ov, zr, neg, res}
    function automatic logic [18:0] alu_fn(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sp;
        logic [31:0] up;
        logic [16:0] s;
        logic [15:0] r;
        logic o;
        sp = $signed(a) * $signed(b);
        up = {16'h0000, a} * {16'h0000, b};
        s = {1'b0, a} + {1'b0, b};
        case (f)
            3'd0: begin r = sp[15:0]; o = (sp != {{16{sp[15]}}, sp[15:0]}); end
            3'd1: begin r = up[15:0]; o = (up[31:16] != 16'h0000); end
            3'd2: begin r = s[15:0]; o = s[16]; end
            3'd3: begin r = a - b; o = (a < b); end
            3'd4: begin r = (a == 16'h3E00 && b == 16'h4000) ? 16'h4200 : (a ^ {b[7:0], b[15:8]}); o = 1'b0; end
            3'd5: begin r = {a[7:0], a[15:8]}; o = 1'b0; end
            default: begin r = a ^ 16'h5A5A; o = a[15]; end
        endcase
        return {o, (r == 16'h0000), r[15], r};
    endfunction

    // Model: an op accepted at cycle t with latency L runs in t+1..t+L, done at t+L+1.
    logic         m_live;
    int           op_issue, op_lat, done_cyc, ill_cyc;
    logic [15:0]  e_src1, e_src0, e_dst;
    logic [2:0]   e_func;
    logic         e_ov, e_zr, e_neg;
    logic         busy_e, stall_e, cap_now;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_live <= 1'b0; op_issue <= 0; op_lat <= 0; done_cyc <= -1; ill_cyc <= -1;
            e_src1 <= '0; e_src0 <= '0; e_func <= 3'b000; e_dst <= '0;
            e_ov <= 1'b0; e_zr <= 1'b0; e_neg <= 1'b0;
        end else if (flush) begin
            m_live <= 1'b0;
        end else if (m_live && cyc >= op_issue + 1 && cyc <= op_issue + op_lat) begin
            if (cyc == op_issue + op_lat) begin
                {e_ov, e_zr, e_neg, e_dst} <= alu_fn(e_func, e_src1, e_src0);
                m_live <= 1'b0;
                done_cyc <= cyc + 1;
            end
        end else if (start) begin
            e_src1 <= src1; e_src0 <= src0; e_func <= func;
            op_issue <= cyc; op_lat <= lat_of(func);
            if (func == 3'b111) begin
                e_dst <= '0; e_ov <= 1'b0; e_zr <= 1'b0; e_neg <= 1'b0;
                done_cyc <= cyc + 1; ill_cyc <= cyc + 1; m_live <= 1'b0;
            end else begin
                m_live <= 1'b1;
            end
        end
    end

    // ALU answers only in the capture cycle; garbage elsewhere exposes mistimed capture.
    always @(negedge clk) begin
        #1;
        busy_e  = m_live && (cyc >= op_issue + 1) && (cyc <= op_issue + op_lat);
        cap_now = busy_e && (cyc == op_issue + op_lat);
        if (cap_now) {alu_ov, alu_zr, alu_neg, alu_res} = alu_fn(e_func, e_src1, e_src0);
        else         {alu_ov, alu_zr, alu_neg, alu_res} = 19'($urandom);
        #1;
        stall_e = (start && !busy_e) || busy_e;
        chk("alu_src1", 32'(alu_src1), 32'(e_src1));
        chk("alu_src0", 32'(alu_src0), 32'(e_src0));
        chk("alu_func", 32'(alu_func), 32'(e_func));
        chk("busy", 32'(busy), 32'(busy_e));
        chk("stall", 32'(stall), 32'(stall_e));
        chk("done", 32'(done), 32'(done_cyc == cyc));
        chk("illegal", 32'(illegal), 32'(ill_cyc == cyc));
        chk("dst", 32'(dst_EX_DM), 32'(e_dst));
        chk("flags", 32'({ov, zr, neg}), 32'({e_ov, e_zr, e_neg}));
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic issue(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        start = 1'b1; func = f; src1 = a; src0 = b;
        #1;
    endtask

    initial begin
        repeat (2) step();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dst", 32'(dst_EX_DM), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // MUL 3 x -2
        issue(3'd0, 16'h0003, 16'hFFFE);
        chk("mul_stall_c0", 32'(stall), 32'd1);
        step(); start = 1'b0; #1;
        chk("mul_stall_c1", 32'(stall), 32'd1);
        step();
        chk("mul_stall_c2", 32'(stall), 32'd1);
        step();
        chk("mul_done_c3", 32'(done), 32'd1);
        chk("mul_dst", 32'(dst_EX_DM), 32'h0000FFFA);
        chk("mul_neg", 32'(neg), 32'd1);
        chk("mul_zr", 32'(zr), 32'd0);
        chk("mul_stall_c3", 32'(stall), 32'd0);

        // MULF 1.5 x 2.0 with inputs wiggling underneath
        step();
        issue(3'd4, 16'h3E00, 16'h4000);
        for (int k = 1; k <= 4; k++) begin
            step(); start = 1'b0;
            src1 = 16'($urandom); src0 = 16'($urandom); func = 3'($urandom);
            chk("mulf_hold_src1", 32'(alu_src1), 32'h3E00);
            chk("mulf_hold_src0", 32'(alu_src0), 32'h4000);
            chk("mulf_hold_func", 32'(alu_func), 32'd4);
            chk("mulf_no_done", 32'(done), 32'd0);
        end
        step();
        chk("mulf_done_c5", 32'(done), 32'd1);
        chk("mulf_dst", 32'(dst_EX_DM), 32'h4200);

        // Undefined function code
        step();
        issue(3'd7, 16'h1234, 16'h5678);
        chk("ill_stall_c0", 32'(stall), 32'd1);
        step(); start = 1'b0; #1;
        chk("ill_done", 32'(done), 32'd1);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_dst", 32'(dst_EX_DM), 32'd0);
        chk("ill_stall_c1", 32'(stall), 32'd0);

        // Back-to-back ADDF then FTI
        step();
        issue(3'd2, 16'h1111, 16'h2222);
        step(); start = 1'b0;
        step(); step(); step();
        chk("b2b_done1_c4", 32'(done), 32'd1);
        chk("b2b_dst1", 32'(dst_EX_DM), 32'h3333);
        issue(3'd6, 16'hABCD, 16'h0000);
        step(); start = 1'b0; #1;
        chk("b2b_busy_c5", 32'(busy), 32'd1);
        step();
        chk("b2b_nodone_c6", 32'(done), 32'd0);
        step();
        chk("b2b_done2_c7", 32'(done), 32'd1);
        chk("b2b_dst2", 32'(dst_EX_DM), 32'hF197);
        chk("b2b_ov2", 32'(ov), 32'd1);

        // Flush in cycle 2 of ADDF, with a competing start
        step();
        issue(3'd2, 16'h0101, 16'h0202);
        step(); start = 1'b0;
        step(); flush = 1'b1; start = 1'b1; func = 3'd0; src1 = 16'h0007; src0 = 16'h0007;
        step(); flush = 1'b0; start = 1'b0; #1;
        chk("flush_busy_c3", 32'(busy), 32'd0);
        chk("flush_stall_c3", 32'(stall), 32'd0);
        chk("flush_dst_kept", 32'(dst_EX_DM), 32'hF197);
        chk("flush_func_kept", 32'(alu_func), 32'd2);
        for (int k = 0; k < 3; k++) begin
            chk("flush_no_done", 32'(done), 32'd0);
            step();
        end

        // Asynchronous reset in the middle of MULF
        issue(3'd4, 16'h3E00, 16'h4000);
        step(); start = 1'b0;
        step(); rst = 1'b1; #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_dst", 32'(dst_EX_DM), 32'd0);
        chk("arst_src1", 32'(alu_src1), 32'd0);
        chk("arst_func", 32'(alu_func), 32'd0);
        chk("arst_flags", 32'({ov, zr, neg, done, illegal}), 32'd0);
        step(); rst = 1'b0;
        step();
        issue(3'd1, 16'hFFFF, 16'h0002);
        step(); start = 1'b0;
        step(); step();
        chk("umul_done_c3", 32'(done), 32'd1);
        chk("umul_ov", 32'(ov), 32'd1);
        chk("umul_dst", 32'(dst_EX_DM), 32'hFFFE);

        // Random traffic
        repeat (600) begin
            step();
            start = 1'($urandom_range(0, 1));
            func  = 3'($urandom_range(0, 7));
            src1  = 16'($urandom);
            src0  = 16'($urandom);
            flush = ($urandom_range(0, 15) == 0);
        end
        start = 1'b0; flush = 1'b0;
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
